// File: rtl/game_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : game_round_controller
// Description : Multi-round reaction-game sequencer: seeds the LFSR, paints a
//               target, times the stop response and tracks rounds and hits.
// Revision    : 1.0 - initial release
// ============================================================================
module game_round_controller #(
    parameter  int ROUNDS         = 4,
    parameter  int TIMEOUT_CYCLES = 50000000,
    parameter  int SEED_CYCLES    = 1,
    localparam int RW             = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
    localparam int HW             = $clog2(ROUNDS + 1),
    localparam int TW             = $clog2(TIMEOUT_CYCLES),
    localparam int SW             = (SEED_CYCLES > 1) ? $clog2(SEED_CYCLES) : 1
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          iStart,
    input  logic          iStop,
    output logic          oEnableLFSR,
    output logic          oPintar,
    output logic          oResetPintar,
    output logic          oTimeout,
    output logic [RW-1:0] oRound,
    output logic [HW-1:0] oHits,
    output logic          oGameOver,
    output logic          oBusy
);

    localparam logic [2:0] S_SEED  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_PAINT = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [SW-1:0] c_SEED_LAST  = SW'(SEED_CYCLES - 1);
    localparam logic [TW-1:0] c_TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] c_ROUND_LAST = RW'(ROUNDS - 1);

    logic [2:0]    r_state;
    logic [SW-1:0] r_seedCnt;
    logic [TW-1:0] r_timer;
    logic [RW-1:0] r_round;
    logic [HW-1:0] r_hits;
    logic          r_running;
    logic          r_timeout;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state   <= S_SEED;
            r_seedCnt <= '0;
            r_timer   <= '0;
            r_round   <= '0;
            r_hits    <= '0;
            r_running <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_SEED: begin
                    if (r_seedCnt == c_SEED_LAST) begin
                        r_seedCnt <= '0;
                        r_state   <= r_running ? S_PAINT : S_WAIT;
                    end else begin
                        r_seedCnt <= r_seedCnt + SW'(1);
                    end
                end
                S_WAIT: begin
                    if (iStart) begin
                        r_running <= 1'b1;
                        r_state   <= S_PAINT;
                    end
                end
                S_PAINT: begin
                    r_timer <= '0;
                    r_state <= S_PLAY;
                end
                S_PLAY: begin
                    // A stop on the final timer cycle still counts as a hit.
                    if (iStop) begin
                        r_hits  <= r_hits + HW'(1);
                        r_state <= S_CLEAR;
                    end else if (r_timer == c_TIMER_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_CLEAR;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_CLEAR: begin
                    if (r_round == c_ROUND_LAST) begin
                        r_running <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_round <= r_round + RW'(1);
                        r_state <= S_SEED;
                    end
                end
                S_DONE: begin
                    if (iStart) begin
                        r_round   <= '0;
                        r_hits    <= '0;
                        r_running <= 1'b1;
                        r_state   <= S_SEED;
                    end
                end
                default: begin
                    r_seedCnt <= '0;
                    r_running <= 1'b0;
                    r_state   <= S_SEED;
                end
            endcase
        end
    end

    assign oEnableLFSR  = (r_state == S_SEED);
    assign oPintar      = (r_state == S_PAINT);
    assign oResetPintar = (r_state == S_CLEAR);
    assign oGameOver    = (r_state == S_DONE);
    assign oBusy        = (r_state == S_PAINT) || (r_state == S_PLAY) || (r_state == S_CLEAR);
    assign oTimeout     = r_timeout;
    assign oRound       = r_round;
    assign oHits        = r_hits;

endmodule
`default_nettype wire

// File: tb/tb_game_round_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_round_controller
// Description : Directed self-checking bench for game_round_controller
//               (ROUNDS=3, TIMEOUT_CYCLES=8, SEED_CYCLES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_round_controller;

    localparam int ROUNDS         = 3;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int SEED_CYCLES    = 2;

    logic       iClk = 1'b0;
    logic       iReset;
    logic       iStart;
    logic       iStop;
    logic       oEnableLFSR;
    logic       oPintar;
    logic       oResetPintar;
    logic       oTimeout;
    logic [1:0] oRound;
    logic [1:0] oHits;
    logic       oGameOver;
    logic       oBusy;

    int r_checks = 0;
    int r_errors = 0;

    game_round_controller #(
        .ROUNDS         (ROUNDS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SEED_CYCLES    (SEED_CYCLES)
    ) u_dut (
        .iClk         (iClk),
        .iReset       (iReset),
        .iStart       (iStart),
        .iStop        (iStop),
        .oEnableLFSR  (oEnableLFSR),
        .oPintar      (oPintar),
        .oResetPintar (oResetPintar),
        .oTimeout     (oTimeout),
        .oRound       (oRound),
        .oHits        (oHits),
        .oGameOver    (oGameOver),
        .oBusy        (oBusy)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input int obs, input int exp);
        r_checks++;
        if (obs != exp) begin
            r_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full output snapshot: lfsr, paint, clear, timeout, round, hits, done, busy.
    task automatic expOut(input string tag, input int en, input int p, input int rp,
                          input int to, input int rnd, input int h, input int go,
                          input int b);
        chk({tag, ".lfsr"},    int'(oEnableLFSR),  en);
        chk({tag, ".pintar"},  int'(oPintar),      p);
        chk({tag, ".rstPint"}, int'(oResetPintar), rp);
        chk({tag, ".timeout"}, int'(oTimeout),     to);
        chk({tag, ".round"},   int'(oRound),       rnd);
        chk({tag, ".hits"},    int'(oHits),        h);
        chk({tag, ".over"},    int'(oGameOver),    go);
        chk({tag, ".busy"},    int'(oBusy),        b);
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        iReset = 1'b1;
        iStart = 1'b0;
        iStop  = 1'b0;
        tick();
        tick();
        expOut("rst", 1, 0, 0, 0, 0, 0, 0, 0);
        iReset = 1'b0;
        tick();
        expOut("seed2", 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expOut("wait", 0, 0, 0, 0, 0, 0, 0, 0);

        iStop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            expOut("waitStop", 0, 0, 0, 0, 0, 0, 0, 0);
        end
        iStop = 1'b0;

        // Round 0: start, hit on the 3rd PLAY cycle
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        expOut("paint0", 0, 1, 0, 0, 0, 0, 0, 1);
        tick();
        expOut("play0c1", 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        tick();
        expOut("play0c3", 0, 0, 0, 0, 0, 0, 0, 1);
        iStop = 1'b1;
        tick();
        iStop = 1'b0;
        expOut("clear0", 0, 0, 1, 0, 0, 1, 0, 1);
        tick();
        expOut("seed1a", 1, 0, 0, 0, 1, 1, 0, 0);
        tick();
        expOut("seed1b", 1, 0, 0, 0, 1, 1, 0, 0);
        tick();
        expOut("paint1", 0, 1, 0, 0, 1, 1, 0, 1);

        // Round 1: timeout after exactly 8 PLAY cycles
        tick();
        for (int i = 1; i <= TIMEOUT_CYCLES; i++) begin
            expOut($sformatf("play1c%0d", i), 0, 0, 0, 0, 1, 1, 0, 1);
            tick();
        end
        expOut("clear1", 0, 0, 1, 1, 1, 1, 0, 1);
        tick();
        expOut("seed2a", 1, 0, 0, 0, 2, 1, 0, 0);
        tick();
        tick();
        expOut("paint2", 0, 1, 0, 0, 2, 1, 0, 1);

        // Round 2: iStart ignored in PLAY, stop on the 8th cycle beats timeout
        tick();
        for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
            expOut($sformatf("play2c%0d", i), 0, 0, 0, 0, 2, 1, 0, 1);
            iStart = (i == 2);
            tick();
        end
        iStart = 1'b0;
        expOut("play2c8", 0, 0, 0, 0, 2, 1, 0, 1);
        iStop = 1'b1;
        tick();
        iStop = 1'b0;
        expOut("clear2", 0, 0, 1, 0, 2, 2, 0, 1);
        tick();
        expOut("done", 0, 0, 0, 0, 2, 2, 1, 0);
        tick();
        expOut("doneHold", 0, 0, 0, 0, 2, 2, 1, 0);

        // Restart from DONE, score a hit, then reset in round 1 PLAY cycle 4
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        expOut("restart", 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        expOut("rPaint0", 0, 1, 0, 0, 0, 0, 0, 1);
        tick();
        iStop = 1'b1;
        tick();
        iStop = 1'b0;
        expOut("rClear0", 0, 0, 1, 0, 0, 1, 0, 1);
        tick();
        tick();
        tick();
        expOut("rPaint1", 0, 1, 0, 0, 1, 1, 0, 1);
        tick();
        tick();
        tick();
        tick();
        expOut("rPlay1c4", 0, 0, 0, 0, 1, 1, 0, 1);
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        expOut("midRst", 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expOut("midRstSeed", 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expOut("midRstWait", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expOut("midRstIdle", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_round_controller.md
# game_round_controller

Parametrised top-level game sequencer for the reaction game. It runs a multi-round game: it seeds the LFSR, paints a target, and times the player's stop response against a timeout. It then clears the display and advances the round, tracking hits until the game ends. It sits between the button debouncers (start/stop) and the LFSR and paint blocks, and drives the score and round displays.

## Interface
Parameters:
- ROUNDS, 4: rounds per game; must be ≥1.
- TIMEOUT_CYCLES, 50000000: PLAY window length in clocks; must be ≥2.
- SEED_CYCLES, 1: clocks oEnableLFSR is held high per seeding phase; must be ≥1.

Derived widths:
- RW = max(1, clog2(ROUNDS)).
- HW = clog2(ROUNDS+1).
- TW = clog2(TIMEOUT_CYCLES).
- SW = max(1, clog2(SEED_CYCLES)).

Ports:
- iClk, in, 1: sole clock, all state changes on its rising edge.
- iReset, in, 1: synchronous, active-high reset.
- iStart, in, 1: start request, level-sampled; already debounced/one-shot upstream.
- iStop, in, 1: player stop/hit, level-sampled.
- oEnableLFSR, out, 1: high while seeding.
- oPintar, out, 1: one-cycle paint pulse.
- oResetPintar, out, 1: one-cycle clear pulse.
- oTimeout, out, 1: one-cycle pulse when a round ends by timeout.
- oRound, out, RW: current round index, 0-based.
- oHits, out, HW: hits in current game.
- oGameOver, out, 1: high in DONE.
- oBusy, out, 1: high when state is PAINT, PLAY or CLEAR.

## Operation
- Registers: state, seed counter (SW), timer (TW), round (RW), hits (HW), running flag, oTimeout.
- Outputs are Moore decodes of state, except oTimeout, which is registered.
- States and transitions:
  - SEED: oEnableLFSR=1 for exactly SEED_CYCLES cycles. Then goes to PAINT if running=1, else WAIT.
  - WAIT: idle. iStart=1 → PAINT and sets running=1.
  - PAINT: oPintar=1 for one cycle; clears timer → PLAY.
  - PLAY: timer increments each cycle.
    - iStop=1 → CLEAR with hits+1 (hit).
    - Otherwise, when timer==TIMEOUT_CYCLES-1 → CLEAR with oTimeout set (miss).
  - CLEAR: oResetPintar=1 for one cycle.
    - If round==ROUNDS-1 → DONE and clears running.
    - Otherwise round+1 → SEED.
  - DONE: oGameOver=1; round and hits hold their final values. iStart=1 → SEED with round=0, hits=0, running=1.
- iStart is ignored outside WAIT and DONE. iStop is ignored outside PLAY.
- iStop and timeout in the same PLAY cycle: the hit wins, and oTimeout stays 0.
- hits never exceeds ROUNDS, so there is no overflow; round never wraps within a game.
- Unreachable state encodings → SEED on the next edge, with running=0.

## Timing
- Reset: while iReset=1 at an edge, the next state is SEED; seed counter, timer, round, hits, running and oTimeout all clear to 0.
- Output values after reset:
  - oEnableLFSR=1.
  - oPintar, oResetPintar, oTimeout, oGameOver and oBusy all 0.
  - oRound=0 and oHits=0.
- Reset mid-game (any state): same behaviour as above. After SEED the block lands in WAIT, and no pulse is emitted.
- iStart sampled high in WAIT at edge k: oPintar is high during cycle k+1 only, and PLAY occupies cycles k+2 onward.
- PLAY with no iStop lasts exactly TIMEOUT_CYCLES cycles. oResetPintar and oTimeout are then high together for one cycle.
- iStop sampled high in PLAY at edge k: oResetPintar is high during cycle k+1, and oHits shows the increment from cycle k+1.
- Round-to-round gap: CLEAR(1) + SEED(SEED_CYCLES) + PAINT(1), with no start needed.
- oRound increments on the CLEAR→SEED edge.

## Test plan
All scenarios use ROUNDS=3, TIMEOUT_CYCLES=8, SEED_CYCLES=2.
- Reset: hold iReset for 2 cycles, then release → oEnableLFSR=1 for 2 cycles, then WAIT with all pulse outputs 0, oRound=0, oHits=0. A 5-cycle iStop pulse in WAIT has no effect.
- Start and hit: iStart for 1 cycle → oPintar for 1 cycle on the next cycle. iStop on the 3rd PLAY cycle → oResetPintar for 1 cycle, oHits=1, oRound=1, oEnableLFSR for 2 cycles, then oPintar again.
- Timeout: no iStop → PLAY lasts exactly 8 cycles; oTimeout=oResetPintar=1 for the same single cycle; oHits unchanged.
- Simultaneous: iStop asserted on the 8th PLAY cycle → counted as a hit, oTimeout=0.
- Full game: hit, timeout, hit → oGameOver=1, oHits=2, oRound=2 held. iStart during PLAY is ignored. iStart in DONE → counters read 0 and seeding restarts.
- Reset mid-PLAY on cycle 4 → no oResetPintar; oRound=0, oHits=0; after 2 seed cycles the block is in WAIT (oBusy=0).
